vector_writeback_arbiter: RTL and testbench

VECTOR_WRITEBACK_ARBITER -- requirements
Module: vector_writeback_arbiter

---
 rtl/vector_writeback_arbiter.sv | 103 ++++++++++
 tb/tb_vector_writeback_arbiter.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vector_writeback_arbiter.sv
// Vector register-file writeback arbiter: one ALU source and a FIFO-buffered LSU source
// share a single registered RF write port. Starvation guard lets the ALU win every 3rd cycle.
module vector_writeback_arbiter #(
  parameter int unsigned THREADS = 4,
  parameter int unsigned DEPTH   = 4
) (
  input  logic                            clk,
  input  logic                            nRST,
  input  logic                            alu_valid,
  output logic                            alu_ready,
  input  logic [4:0]                      alu_wsel,
  input  logic [THREADS-1:0]              alu_wen,
  input  logic [THREADS-1:0][31:0]        alu_wdata,
  input  logic                            lsu_valid,
  output logic                            lsu_ready,
  input  logic [4:0]                      lsu_wsel,
  input  logic [THREADS-1:0]              lsu_wen,
  input  logic [THREADS-1:0][31:0]        lsu_wdata,
  output logic [4:0]                      rf_wsel,
  output logic [THREADS-1:0]              rf_wen,
  output logic [THREADS-1:0][31:0]        rf_wdata,
  output logic [$clog2(DEPTH):0]          lsu_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef struct packed {
    logic [4:0]               wsel;
    logic [THREADS-1:0]       wen;
    logic [THREADS-1:0][31:0] wdata;
  } entry_t;

  entry_t        mem [DEPTH];
  entry_t        head;
  entry_t        win;
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [1:0]    starve;
  logic [1:0]    starve_next;
  logic          push;
  logic          pop;
  logic          grant;

  assign head      = mem[rptr];
  assign lsu_ready = (lsu_count != CW'(DEPTH));
  assign alu_ready = alu_valid && ((lsu_count == '0) || (starve == 2'd2));
  assign push      = lsu_valid && lsu_ready;
  // The queue head only pops when the ALU is not taking the write port.
  assign pop       = (lsu_count != '0) && !alu_ready;
  assign grant     = alu_ready || pop;

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= {lsu_wsel, lsu_wen, lsu_wdata};
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      wptr      <= '0;
      rptr      <= '0;
      lsu_count <= '0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      case ({push, pop})
        2'b10:   lsu_count <= lsu_count + CW'(1);
        2'b01:   lsu_count <= lsu_count - CW'(1);
        default: lsu_count <= lsu_count;
      endcase
    end
  end

  always_comb begin
    starve_next = starve;
    if (!alu_valid || alu_ready) starve_next = 2'd0;
    else if (starve != 2'd2)     starve_next = starve + 2'd1;
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) starve <= 2'd0;
    else       starve <= starve_next;
  end

  always_comb begin
    win = head;
    if (alu_ready) win = {alu_wsel, alu_wen, alu_wdata};
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      rf_wsel  <= '0;
      rf_wen   <= '0;
      rf_wdata <= '0;
    end else if (grant) begin
      rf_wsel  <= win.wsel;
      rf_wdata <= win.wdata;
      rf_wen   <= (win.wsel == 5'd0) ? '0 : win.wen;
    end else begin
      rf_wen   <= '0;
    end
  end

endmodule

// File: tb/tb_vector_writeback_arbiter.sv
// Self-checking bench: queue-based reference model of the arbiter, compared every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_vector_writeback_arbiter;

  localparam int unsigned THREADS = 4;
  localparam int unsigned DEPTH   = 4;

  logic                     clk = 1'b0;
  logic                     nRST;
  logic                     alu_valid;
  logic                     alu_ready;
  logic [4:0]               alu_wsel;
  logic [THREADS-1:0]       alu_wen;
  logic [THREADS-1:0][31:0] alu_wdata;
  logic                     lsu_valid;
  logic                     lsu_ready;
  logic [4:0]               lsu_wsel;
  logic [THREADS-1:0]       lsu_wen;
  logic [THREADS-1:0][31:0] lsu_wdata;
  logic [4:0]               rf_wsel;
  logic [THREADS-1:0]       rf_wen;
  logic [THREADS-1:0][31:0] rf_wdata;
  logic [$clog2(DEPTH):0]   lsu_count;

  vector_writeback_arbiter #(.THREADS(THREADS), .DEPTH(DEPTH)) dut (
    .clk(clk), .nRST(nRST),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_wsel(alu_wsel),
    .alu_wen(alu_wen), .alu_wdata(alu_wdata),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_wsel(lsu_wsel),
    .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata),
    .rf_wsel(rf_wsel), .rf_wen(rf_wen), .rf_wdata(rf_wdata),
    .lsu_count(lsu_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]               wsel;
    logic [THREADS-1:0]       wen;
    logic [THREADS-1:0][31:0] wdata;
  } ent_t;

  // Reference model: pending LSU writes, consecutive ALU wait cycles, last RF write.
  ent_t                     q[$];
  int                       waited;
  logic [4:0]               m_wsel;
  logic [THREADS-1:0]       m_wen;
  logic [THREADS-1:0][31:0] m_wdata;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    q.delete();
    waited  = 0;
    m_wsel  = '0;
    m_wen   = '0;
    m_wdata = '0;
  endtask

  // Called at a negedge with inputs already driven; returns at the following negedge.
  task automatic step();
    bit                       aw;
    bit                       do_push;
    int                       sz;
    ent_t                     pe;
    logic [4:0]               n_wsel;
    logic [THREADS-1:0]       n_wen;
    logic [THREADS-1:0][31:0] n_wdata;
    int                       n_wait;
    #1;
    sz = q.size();
    aw = alu_valid && (sz == 0 || waited >= 2);
    chk("alu_ready", 256'(alu_ready), 256'(aw));
    chk("lsu_ready", 256'(lsu_ready), 256'(sz != DEPTH));
    chk("lsu_count", 256'(lsu_count), 256'(sz));
    chk("rf_wsel",   256'(rf_wsel),   256'(m_wsel));
    chk("rf_wen",    256'(rf_wen),    256'(m_wen));
    chk("rf_wdata",  256'(rf_wdata),  256'(m_wdata));
    n_wsel  = m_wsel;
    n_wdata = m_wdata;
    n_wen   = '0;
    if (aw) begin
      n_wsel  = alu_wsel;
      n_wdata = alu_wdata;
      n_wen   = (alu_wsel == 5'd0) ? '0 : alu_wen;
    end else if (sz != 0) begin
      n_wsel  = q[0].wsel;
      n_wdata = q[0].wdata;
      n_wen   = (q[0].wsel == 5'd0) ? '0 : q[0].wen;
    end
    n_wait   = (!alu_valid || aw) ? 0 : ((waited >= 2) ? 2 : waited + 1);
    do_push  = lsu_valid && (sz != DEPTH);
    pe.wsel  = lsu_wsel;
    pe.wen   = lsu_wen;
    pe.wdata = lsu_wdata;
    @(posedge clk);
    if (!aw && sz != 0) void'(q.pop_front());
    if (do_push) q.push_back(pe);
    m_wsel  = n_wsel;
    m_wen   = n_wen;
    m_wdata = n_wdata;
    waited  = n_wait;
    @(negedge clk);
  endtask

  task automatic do_reset();
    alu_valid = 1'b0;
    lsu_valid = 1'b0;
    nRST      = 1'b0;
    #1;
    chk("rst_rf_wsel",   256'(rf_wsel),   256'(0));
    chk("rst_rf_wen",    256'(rf_wen),    256'(0));
    chk("rst_rf_wdata",  256'(rf_wdata),  256'(0));
    chk("rst_lsu_count", 256'(lsu_count), 256'(0));
    chk("rst_lsu_ready", 256'(lsu_ready), 256'(1));
    model_clear();
    @(posedge clk);
    @(negedge clk);
    #1;
    nRST = 1'b1;
  endtask

  task automatic idle(input int n);
    alu_valid = 1'b0;
    lsu_valid = 1'b0;
    repeat (n) step();
  endtask

  task automatic rand_lsu();
    lsu_wsel  = 5'($urandom_range(1, 31));
    lsu_wen   = THREADS'($urandom);
    for (int i = 0; i < THREADS; i++) lsu_wdata[i] = $urandom;
  endtask

  initial begin
    nRST      = 1'b0;
    alu_valid = 1'b0;
    alu_wsel  = '0;
    alu_wen   = '0;
    alu_wdata = '0;
    lsu_valid = 1'b0;
    lsu_wsel  = '0;
    lsu_wen   = '0;
    lsu_wdata = '0;
    model_clear();
    @(negedge clk);
    do_reset();

    // ALU only: granted same cycle, visible one cycle later
    alu_valid = 1'b1;
    alu_wsel  = 5'd5;
    alu_wen   = 4'b1010;
    alu_wdata = {32'd4, 32'd3, 32'd2, 32'd1};
    #1;
    chk("alu_only_ready", 256'(alu_ready), 256'(1));
    step();
    chk("alu_only_wsel",  256'(rf_wsel),  256'(5));
    chk("alu_only_wen",   256'(rf_wen),   256'(4'b1010));
    chk("alu_only_wdata", 256'(rf_wdata), 256'({32'd4, 32'd3, 32'd2, 32'd1}));

    // Register zero write is consumed but masked
    alu_wsel = 5'd0;
    alu_wen  = 4'b1111;
    #1;
    chk("r0_ready", 256'(alu_ready), 256'(1));
    step();
    chk("r0_wen", 256'(rf_wen), 256'(0));
    alu_valid = 1'b0;
    step();

    // Concurrent push/pop across pointer wrap
    lsu_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      rand_lsu();
      lsu_wsel = 5'(i + 1);
      step();
      chk("wrap_count", 256'(lsu_count), 256'(1));
    end
    idle(3);

    // Starvation: ALU waits two cycles, wins the third, head stays queued
    lsu_valid = 1'b1;
    rand_lsu();
    step();
    alu_valid = 1'b1;
    alu_wsel  = 5'd9;
    alu_wen   = 4'b1111;
    for (int k = 0; k < 3; k++) begin
      rand_lsu();
      #1;
      chk("starve_ready", 256'(alu_ready), 256'(k == 2));
      step();
    end
    chk("starve_no_pop", 256'(lsu_count), 256'(2));
    idle(4);

    // Fill: ALU every 3rd cycle lets the queue grow to full
    alu_valid = 1'b1;
    lsu_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      rand_lsu();
      alu_wsel = 5'($urandom_range(1, 31));
      step();
    end
    chk("fill_count", 256'(lsu_count), 256'(DEPTH));
    chk("fill_ready", 256'(lsu_ready), 256'(0));
    rand_lsu();
    repeat (4) step();
    alu_valid = 1'b0;
    repeat (3) step();

    // Reset with entries queued: none may ever be written
    do_reset();
    chk("post_rst_count", 256'(lsu_count), 256'(0));
    idle(1);
    chk("post_rst_wen", 256'(rf_wen), 256'(0));
    idle(6);

    // Randomized traffic with a mid-run reset
    for (int c = 0; c < 800; c++) begin
      if (c == 400) begin
        lsu_valid = 1'b1;
        step();
        do_reset();
      end
      alu_valid = ($urandom_range(0, 99) < 55);
      lsu_valid = ($urandom_range(0, 99) < 60);
      alu_wsel  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      alu_wen   = THREADS'($urandom);
      for (int i = 0; i < THREADS; i++) alu_wdata[i] = $urandom;
      rand_lsu();
      if ($urandom_range(0, 7) == 0) lsu_wsel = 5'd0;
      step();
    end
    idle(DEPTH + 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
